// File: rtl/fdsync_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fdsync_pkg
//  Description : Shared helpers for the fdsync_bank register bank.
//                - clog2 and select-width derivation
//                - per-channel status flag record
//  Revision    : 1.0  initial release
// ============================================================================
package fdsync_pkg;

    // Ceiling log2 as a constant function, usable in parameter expressions.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Select width: a single-channel bank still needs a one-bit sel port.
    function automatic int cw_of(input int channels);
        return (channels <= 1) ? 1 : clog2(channels);
    endfunction

    // Per-channel status. The data words (shadow/active) are sized by the
    // instantiating WIDTH, so they live beside this record in fdsync_chan.
    typedef struct packed {
        logic pending;
        logic overrun;
    } chan_flags_t;

endpackage : fdsync_pkg
`default_nettype wire

// File: rtl/fdsync_chan.sv
`default_nettype none
// ============================================================================
//  Module      : fdsync_chan
//  Description : One double-buffered channel of fdsync_bank.
//                Deferred channels write a shadow word and transfer it to
//                the active word on commit; immediate channels write both
//                words on the same edge.
//  Ports       : clk, reset (async, active-high), d, wr, commit
//                q (active word), shad (shadow word), pending, overrun
//  Revision    : 1.0  initial release
// ============================================================================
module fdsync_chan
    import fdsync_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               IMMEDIATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic             wr,
    input  logic             commit,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] shad,
    output logic             pending,
    output logic             overrun
);

    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_active;
    chan_flags_t      r_flags;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow <= RESET_VAL;
            r_active <= RESET_VAL;
            r_flags  <= '0;
        end else if (IMMEDIATE) begin
            // Behaves as the original load-enable flop; flags never leave 0.
            if (wr) begin
                r_shadow <= d;
                r_active <= d;
            end
        end else begin
            // Active takes the shadow as it stood before this edge, so a
            // write landing together with commit is held for the next commit.
            if (commit && r_flags.pending) begin
                r_active <= r_shadow;
            end
            if (wr) begin
                r_shadow <= d;
            end
            if (wr) begin
                r_flags.pending <= 1'b1;
            end else if (commit) begin
                r_flags.pending <= 1'b0;
            end
            // Commit clears overrun even when a write collides with it.
            if (commit) begin
                r_flags.overrun <= 1'b0;
            end else if (wr && r_flags.pending) begin
                r_flags.overrun <= 1'b1;
            end
        end
    end

    assign q       = r_active;
    assign shad    = r_shadow;
    assign pending = r_flags.pending;
    assign overrun = r_flags.overrun;

endmodule : fdsync_chan
`default_nettype wire

// File: rtl/fdsync_bank.sv
`default_nettype none
// ============================================================================
//  Module      : fdsync_bank
//  Description : Bank of CHANNELS double-buffered WIDTH-bit registers with a
//                single atomic commit strobe. Channels flagged in
//                IMMEDIATE_MASK bypass the shadow stage.
//  Ports       : clk        in   clock
//                reset      in   async active-high reset
//                d          in   write data
//                ld         in   write strobe
//                sel        in   channel select
//                commit     in   shadow->active transfer strobe
//                q          out  active words, channel n at [n*WIDTH +: WIDTH]
//                rd_q       out  shadow word of channel sel (combinational)
//                pending    out  per-channel write awaiting commit
//                overrun    out  per-channel sticky double-write flag
//                commit_ack out  pulse after a commit that moved data
//  Revision    : 1.0  initial release
// ============================================================================
module fdsync_bank
    import fdsync_pkg::*;
#(
    parameter int                  WIDTH          = 16,
    parameter int                  CHANNELS       = 4,
    parameter logic [WIDTH-1:0]    RESET_VAL      = '0,
    parameter logic [CHANNELS-1:0] IMMEDIATE_MASK = '0,
    localparam int                 c_CW           = cw_of(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          d,
    input  logic                      ld,
    input  logic [c_CW-1:0]           sel,
    input  logic                      commit,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [WIDTH-1:0]          rd_q,
    output logic [CHANNELS-1:0]       pending,
    output logic [CHANNELS-1:0]       overrun,
    output logic                      commit_ack
);

    logic [CHANNELS-1:0]       w_wr;
    logic [CHANNELS*WIDTH-1:0] w_shad;
    logic                      r_commit_ack;

    // Out-of-range sel matches no channel, so such writes are dropped.
    always_comb begin
        w_wr = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            w_wr[n] = ld && (sel == c_CW'(n));
        end
    end

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
            fdsync_chan #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL),
                .IMMEDIATE (IMMEDIATE_MASK[g])
            ) u_chan (
                .clk     (clk),
                .reset   (reset),
                .d       (d),
                .wr      (w_wr[g]),
                .commit  (commit),
                .q       (q[g*WIDTH +: WIDTH]),
                .shad    (w_shad[g*WIDTH +: WIDTH]),
                .pending (pending[g]),
                .overrun (overrun[g])
            );
        end
    endgenerate

    always_comb begin
        rd_q = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            if (sel == c_CW'(n)) begin
                rd_q = w_shad[n*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_commit_ack <= 1'b0;
        end else begin
            r_commit_ack <= commit && (|pending);
        end
    end

    assign commit_ack = r_commit_ack;

endmodule : fdsync_bank
`default_nettype wire

// File: tb/tb_fdsync_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fdsync_bank
//  Description : Directed self-checking bench for fdsync_bank
//                (WIDTH=16, CHANNELS=4, IMMEDIATE_MASK=4'b0100).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fdsync_bank;

    logic        clk;
    logic        reset;
    logic [15:0] d;
    logic        ld;
    logic [1:0]  sel;
    logic        commit;
    logic [63:0] q;
    logic [15:0] rd_q;
    logic [3:0]  pending;
    logic [3:0]  overrun;
    logic        commit_ack;

    int total;
    int bad;

    fdsync_bank #(
        .WIDTH          (16),
        .CHANNELS       (4),
        .RESET_VAL      (16'h0000),
        .IMMEDIATE_MASK (4'b0100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .d          (d),
        .ld         (ld),
        .sel        (sel),
        .commit     (commit),
        .q          (q),
        .rd_q       (rd_q),
        .pending    (pending),
        .overrun    (overrun),
        .commit_ack (commit_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] qch(input int n);
        return q[n*16 +: 16];
    endfunction

    // Advance one rising edge and settle; inputs change only after this.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; ld = 1'b1; commit = 1'b1; sel = 2'd0; d = 16'hFFFF;
        tick(); tick();
        total++; if (q !== 64'h0) begin bad++; $display("FAIL reset_q got=%h want=%h", q, 64'h0); end
        total++; if (pending !== 4'b0000) begin bad++; $display("FAIL reset_pending got=%b want=%b", pending, 4'b0000); end
        total++; if (overrun !== 4'b0000) begin bad++; $display("FAIL reset_overrun got=%b want=%b", overrun, 4'b0000); end
        total++; if (commit_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b want=%b", commit_ack, 1'b0); end
        ld = 1'b0; commit = 1'b0;
        reset = 1'b0;
        tick(); tick();
        total++; if (q !== 64'h0) begin bad++; $display("FAIL release_q got=%h want=%h", q, 64'h0); end
        total++; if (pending !== 4'b0000) begin bad++; $display("FAIL release_pending got=%b want=%b", pending, 4'b0000); end
    endtask

    task automatic test_deferred();
        sel = 2'd1; d = 16'hA5A5; ld = 1'b1;
        tick();
        ld = 1'b0;
        total++; if (pending !== 4'b0010) begin bad++; $display("FAIL def_pending got=%b want=%b", pending, 4'b0010); end
        total++; if (qch(1) !== 16'h0000) begin bad++; $display("FAIL def_q1_before got=%h want=%h", qch(1), 16'h0000); end
        total++; if (rd_q !== 16'hA5A5) begin bad++; $display("FAIL def_rd_q got=%h want=%h", rd_q, 16'hA5A5); end
        commit = 1'b1;
        tick();
        commit = 1'b0;
        total++; if (qch(1) !== 16'hA5A5) begin bad++; $display("FAIL def_q1_after got=%h want=%h", qch(1), 16'hA5A5); end
        total++; if (pending !== 4'b0000) begin bad++; $display("FAIL def_pending_clr got=%b want=%b", pending, 4'b0000); end
        total++; if (commit_ack !== 1'b1) begin bad++; $display("FAIL def_ack got=%b want=%b", commit_ack, 1'b1); end
        tick();
        total++; if (commit_ack !== 1'b0) begin bad++; $display("FAIL def_ack_pulse got=%b want=%b", commit_ack, 1'b0); end
    endtask

    task automatic test_immediate();
        sel = 2'd2; d = 16'h1234; ld = 1'b1;
        tick();
        ld = 1'b0;
        total++; if (qch(2) !== 16'h1234) begin bad++; $display("FAIL imm_q2 got=%h want=%h", qch(2), 16'h1234); end
        total++; if (pending !== 4'b0000) begin bad++; $display("FAIL imm_pending got=%b want=%b", pending, 4'b0000); end
        total++; if (rd_q !== 16'h1234) begin bad++; $display("FAIL imm_rd_q got=%h want=%h", rd_q, 16'h1234); end
        commit = 1'b1;
        tick();
        commit = 1'b0;
        total++; if (commit_ack !== 1'b0) begin bad++; $display("FAIL imm_no_ack got=%b want=%b", commit_ack, 1'b0); end
        total++; if (q !== {16'h0000, 16'h1234, 16'hA5A5, 16'h0000}) begin
            bad++; $display("FAIL imm_q_hold got=%h want=%h", q, {16'h0000, 16'h1234, 16'hA5A5, 16'h0000});
        end
    endtask

    task automatic test_overrun();
        sel = 2'd0; d = 16'h1111; ld = 1'b1;
        tick();
        total++; if (overrun !== 4'b0000) begin bad++; $display("FAIL ovr_first got=%b want=%b", overrun, 4'b0000); end
        d = 16'h2222;
        tick();
        ld = 1'b0;
        total++; if (overrun !== 4'b0001) begin bad++; $display("FAIL ovr_set got=%b want=%b", overrun, 4'b0001); end
        total++; if (rd_q !== 16'h2222) begin bad++; $display("FAIL ovr_rd_q got=%h want=%h", rd_q, 16'h2222); end
        commit = 1'b1;
        tick();
        commit = 1'b0;
        total++; if (qch(0) !== 16'h2222) begin bad++; $display("FAIL ovr_q0 got=%h want=%h", qch(0), 16'h2222); end
        total++; if (overrun !== 4'b0000) begin bad++; $display("FAIL ovr_clr got=%b want=%b", overrun, 4'b0000); end
        total++; if (commit_ack !== 1'b1) begin bad++; $display("FAIL ovr_ack got=%b want=%b", commit_ack, 1'b1); end
    endtask

    task automatic test_same_edge();
        // Channel 3 gets an overrun on the way, channel 1 a normal pending word.
        sel = 2'd3; d = 16'h0011; ld = 1'b1;
        tick();
        d = 16'h00FF;
        tick();
        sel = 2'd1; d = 16'h5A5A;
        tick();
        total++; if (pending !== 4'b1010) begin bad++; $display("FAIL same_pending_pre got=%b want=%b", pending, 4'b1010); end
        total++; if (overrun !== 4'b1000) begin bad++; $display("FAIL same_overrun_pre got=%b want=%b", overrun, 4'b1000); end
        sel = 2'd3; d = 16'hBEEF; commit = 1'b1;
        tick();
        ld = 1'b0; commit = 1'b0;
        total++; if (qch(3) !== 16'h00FF) begin bad++; $display("FAIL same_q3 got=%h want=%h", qch(3), 16'h00FF); end
        total++; if (qch(1) !== 16'h5A5A) begin bad++; $display("FAIL same_q1 got=%h want=%h", qch(1), 16'h5A5A); end
        total++; if (pending !== 4'b1000) begin bad++; $display("FAIL same_pending got=%b want=%b", pending, 4'b1000); end
        total++; if (overrun !== 4'b0000) begin bad++; $display("FAIL same_overrun got=%b want=%b", overrun, 4'b0000); end
        total++; if (rd_q !== 16'hBEEF) begin bad++; $display("FAIL same_shadow3 got=%h want=%h", rd_q, 16'hBEEF); end
        total++; if (commit_ack !== 1'b1) begin bad++; $display("FAIL same_ack got=%b want=%b", commit_ack, 1'b1); end
        commit = 1'b1;
        tick();
        commit = 1'b0;
        total++; if (qch(3) !== 16'hBEEF) begin bad++; $display("FAIL same_q3_next got=%h want=%h", qch(3), 16'hBEEF); end
        total++; if (pending !== 4'b0000) begin bad++; $display("FAIL same_pending_clr got=%b want=%b", pending, 4'b0000); end
    endtask

    task automatic test_reset_mid();
        sel = 2'd0; d = 16'h7777; ld = 1'b1;
        tick();
        ld = 1'b0;
        total++; if (pending !== 4'b0001) begin bad++; $display("FAIL rmid_pending_pre got=%b want=%b", pending, 4'b0001); end
        // Assert between edges: an asynchronous reset acts without a clock.
        #2;
        reset = 1'b1;
        #1;
        total++; if (pending !== 4'b0000) begin bad++; $display("FAIL rmid_async_pending got=%b want=%b", pending, 4'b0000); end
        total++; if (q !== 64'h0) begin bad++; $display("FAIL rmid_async_q got=%h want=%h", q, 64'h0); end
        tick();
        reset = 1'b0;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        total++; if (commit_ack !== 1'b0) begin bad++; $display("FAIL rmid_no_ack got=%b want=%b", commit_ack, 1'b0); end
        total++; if (q !== 64'h0) begin bad++; $display("FAIL rmid_q got=%h want=%h", q, 64'h0); end
        total++; if (rd_q !== 16'h0000) begin bad++; $display("FAIL rmid_shadow0 got=%h want=%h", rd_q, 16'h0000); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1; ld = 1'b0; commit = 1'b0; sel = 2'd0; d = 16'h0000;
        #1;
        test_reset();
        test_deferred();
        test_immediate();
        test_overrun();
        test_same_edge();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fdsync_bank
`default_nettype wire
